bridge_sched: RTL and testbench
===============================

// Module: bridge_sched
// PURPOSE
//  Owns the 16-bit Avalon bridge into SDRAM and sequences the player: LOAD phase (sdcard_init writes
//  the song into SDRAM), then PLAY phase (sequential prefetch reads into a sample FIFO that the I2S
//  serializer drains on demand). Replaces the ad-hoc LOAD/PLAY address mux and free-running play counter.
// PARAMETERS
//  ADDR_W     26         bridge word-address width
//  DATA_W     16         sample / bridge data width
//  FIFO_DEPTH 8          prefetch FIFO entries (power of 2, >=2)
//  END_ADDR   26'h1FFFFF last valid sample word address; playback wraps to 0 after it
// PORTS
//  Clk          in  1       system clock (50 MHz)
//  Reset        in  1       reset, asynchronous, active-high
//  ld_we        in  1       loader write request (level, held until ld_ack)
//  ld_addr      in  25      loader word address
//  ld_data      in  16      loader write data
//  ld_done      in  1       loader finished (ram_init_done)
//  ld_error     in  1       loader failed (ram_init_error)
//  ld_ack       out 1       1-cycle pulse: loader write accepted by SDRAM (to ram_op_begun)
//  pb_enable    in  1       playback enable (switch, already synchronized)
//  smp_req      in  1       1-cycle pulse: serializer wants next sample
//  smp_data     out 16      sample delivered to serializer
//  smp_valid    out 1       1-cycle pulse: smp_data updated
//  underrun     out 1       sticky: smp_req arrived with FIFO empty in PLAY
//  br_address   out ADDR_W  bridge address
//  br_read      out 1       bridge read request
//  br_write     out 1       bridge write request
//  br_write_data out 16     bridge write data
//  br_byte_enable out 2     constant 2'b11 while a request is active, else 2'b00
//  br_acknowledge in 1      bridge ack (1 cycle, completes current request)
//  br_read_data in  16      bridge read data, valid with br_acknowledge
//  state_o      out 2       current state (for LEDR)
// BEHAVIOUR
//  - Reset: state LOAD; all outputs 0; FIFO empty; play address 0; underrun 0. Reset mid-transaction
//    drops br_read/br_write immediately (async); the bridge shares the same reset.
//  - States: LOAD -> PLAY when ld_done=1 and no request outstanding; LOAD -> ERROR on ld_error=1 (wins over
//    ld_done same cycle); PLAY has no exit except Reset; ERROR is terminal (bridge idle, ld_ack 0).
//  - Bridge rule: at most one outstanding request; address/data/read/write registered and held stable
//    until the cycle br_acknowledge=1; request deasserted the following cycle; next request earliest one
//    cycle after that (no back-to-back overlap).
//  - LOAD: ld_we sampled 1 with no request outstanding -> next cycle br_write=1, br_address={1'b0,ld_addr},
//    br_write_data=ld_data. On br_acknowledge: ld_ack=1 for exactly that next cycle. ld_we still high
//    after ld_ack is treated as a new write (loader must advance address).
//  - PLAY: issue br_read at play address when pb_enable=1 and (fifo_count + inflight) < FIFO_DEPTH, so the
//    FIFO can never overflow. On ack: push br_read_data; play address += 1, wrapping END_ADDR -> 0.
//  - pb_enable falling mid-read: outstanding read completes and is pushed; no new reads. FIFO retained.
//  - smp_req with FIFO non-empty: pop; smp_data=head and smp_valid=1 on the next cycle (latency 1).
//    smp_req with FIFO empty (PLAY): smp_data=16'h0000, smp_valid=1, underrun set. smp_req in LOAD/ERROR:
//    ignored, no valid.
//  - Push and pop in same cycle: both happen, count unchanged; pop on the single entry with a
//    simultaneous push returns the old head (no fall-through).
// STRUCTURE
//  - Package bridge_sched_pkg: state_t enum {ST_LOAD=2'd0, ST_PLAY=2'd1, ST_ERROR=2'd2}, ADDR_W/DATA_W
//    localparams, BE_ALL=2'b11.
//  - Sub-module sample_fifo (DEPTH, WIDTH): synchronous FIFO, registered output, count output,
//    same async active-high Reset.
// TESTING
//  1 Reset, ld_we=1 addr 0x000010 data 0xBEEF, ack after 3 cycles -> br_write=1 addr 0x10 data 0xBEEF held
//    3 cycles, ld_ack single pulse, br_write low next cycle.
//  2 ld_done=1 then pb_enable=1, bridge acks every read in 2 cycles with data=addr -> reads at 0..7,
//    stops with FIFO full (8), no 9th read until smp_req.
//  3 Four smp_req pulses -> smp_data 0,1,2,3 each one cycle after req; reads resume at address 8.
//  4 Play address at END_ADDR -> read END_ADDR then 0; no access to END_ADDR+1.
//  5 smp_req with FIFO empty (pb_enable=0 drained) -> smp_data 0x0000, smp_valid 1, underrun stays 1.
//  6 ld_error and ld_done same cycle -> state_o=2, no further br_read/br_write; Reset mid-read -> all 0.

Source files
------------

// File: rtl/bridge_sched_pkg.sv
// Shared types and widths for the SDRAM bridge scheduler.
package bridge_sched_pkg;

    localparam int ADDR_W = 26;
    localparam int DATA_W = 16;

    localparam logic [1:0] BE_ALL = 2'b11;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

endpackage

// File: rtl/bridge_sched_if.sv
// 16-bit Avalon bridge bus between the scheduler (master) and the SDRAM bridge (slave).
interface bridge_sched_if;
    import bridge_sched_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] write_data;
    logic [1:0]        byte_enable;
    logic              acknowledge;
    logic [DATA_W-1:0] read_data;

    modport master (
        output address, read, write, write_data, byte_enable,
        input  acknowledge, read_data
    );

    modport slave (
        input  address, read, write, write_data, byte_enable,
        output acknowledge, read_data
    );

endinterface

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with registered output; a pop loads the current head into dout.
module sample_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Pointer, occupancy and output-register update; the head is read before any same-cycle write lands.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            dout_d   = mem_q[rd_ptr_q];
        end
        if (push && !pop) begin
            count_d = count_q + (PW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PW+1)'(1);
        end
    end

    // Control state registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    // Storage array; contents are don't-care until written, so it carries no reset.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = dout_q;
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/bridge_sched.sv
// Bridge scheduler: arbitrates the SDRAM bridge between the song loader and playback prefetch.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  ST_LOAD  | loader writes forwarded to the bridge, waiting for ld_done
//  ST_PLAY  | sequential prefetch reads into the sample FIFO, no exit
//  ST_ERROR | loader failed; no new bridge requests, samples ignored
module bridge_sched
    import bridge_sched_pkg::*;
#(
    parameter int                FIFO_DEPTH = 8,
    parameter logic [ADDR_W-1:0] END_ADDR   = 26'h1FFFFF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ld_we,
    input  logic [24:0]       ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_done,
    input  logic              ld_error,
    output logic              ld_ack,
    input  logic              pb_enable,
    input  logic              smp_req,
    output logic [DATA_W-1:0] smp_data,
    output logic              smp_valid,
    output logic              underrun,
    output logic [1:0]        state_o,
    bridge_sched_if.master    br
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(FIFO_DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] br_addr_q, br_addr_d;
    logic [DATA_W-1:0] br_wdata_q, br_wdata_d;
    logic              br_read_q, br_read_d;
    logic              br_write_q, br_write_d;
    logic [ADDR_W-1:0] play_addr_q, play_addr_d;
    logic              ld_ack_q, ld_ack_d;
    logic              smp_valid_q, smp_valid_d;
    logic              smp_zero_q, smp_zero_d;
    logic              underrun_q, underrun_d;

    logic              req_busy;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_dout;
    logic [CNT_W:0]    fifo_level;

    assign req_busy   = br_read_q | br_write_q;
    assign fifo_push  = br_read_q & br.acknowledge;
    // Count the in-flight read so an acknowledged read always has a free slot.
    assign fifo_level = {1'b0, fifo_count} + {{CNT_W{1'b0}}, br_read_q};

    // Next-state, bridge request and sample-delivery logic.
    always_comb begin
        state_d     = state_q;
        br_addr_d   = br_addr_q;
        br_wdata_d  = br_wdata_q;
        br_read_d   = br_read_q;
        br_write_d  = br_write_q;
        play_addr_d = play_addr_q;
        fifo_pop    = 1'b0;
        smp_valid_d = 1'b0;
        smp_zero_d  = smp_zero_q;
        underrun_d  = underrun_q;
        ld_ack_d    = br_write_q & br.acknowledge & (state_q == ST_LOAD) & ~ld_error;

        // A request held until acknowledged, then dropped; new issue only from an idle cycle.
        if (req_busy && br.acknowledge) begin
            br_read_d  = 1'b0;
            br_write_d = 1'b0;
        end
        if (fifo_push) begin
            play_addr_d = (play_addr_q == END_ADDR) ? '0 : play_addr_q + ADDR_W'(1);
        end

        unique case (state_q)
            ST_LOAD: begin
                if (ld_error) begin
                    state_d = ST_ERROR;
                end else if (ld_done && !req_busy) begin
                    state_d = ST_PLAY;
                end else if (ld_we && !req_busy && !ld_ack_q) begin
                    // Skipping the ld_ack cycle keeps the just-acknowledged request from being reissued.
                    br_write_d = 1'b1;
                    br_addr_d  = ADDR_W'(ld_addr);
                    br_wdata_d = ld_data;
                end
            end
            ST_PLAY: begin
                if (pb_enable && !req_busy && (fifo_level < DEPTH_L)) begin
                    br_read_d = 1'b1;
                    br_addr_d = play_addr_q;
                end
                if (smp_req) begin
                    smp_valid_d = 1'b1;
                    fifo_pop    = ~fifo_empty;
                    smp_zero_d  = fifo_empty;
                    underrun_d  = underrun_q | fifo_empty;
                end
            end
            default: ;
        endcase
    end

    // State and output registers; reset drops any bridge request immediately.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_LOAD;
            br_addr_q   <= '0;
            br_wdata_q  <= '0;
            br_read_q   <= 1'b0;
            br_write_q  <= 1'b0;
            play_addr_q <= '0;
            ld_ack_q    <= 1'b0;
            smp_valid_q <= 1'b0;
            smp_zero_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            br_addr_q   <= br_addr_d;
            br_wdata_q  <= br_wdata_d;
            br_read_q   <= br_read_d;
            br_write_q  <= br_write_d;
            play_addr_q <= play_addr_d;
            ld_ack_q    <= ld_ack_d;
            smp_valid_q <= smp_valid_d;
            smp_zero_q  <= smp_zero_d;
            underrun_q  <= underrun_d;
        end
    end

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .Clk   (Clk),
        .Reset (Reset),
        .push  (fifo_push),
        .din   (br.read_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign br.address     = br_addr_q;
    assign br.read        = br_read_q;
    assign br.write       = br_write_q;
    assign br.write_data  = br_wdata_q;
    assign br.byte_enable = req_busy ? BE_ALL : 2'b00;
    assign ld_ack         = ld_ack_q;
    assign smp_valid      = smp_valid_q;
    assign smp_data       = smp_zero_q ? '0 : fifo_dout;
    assign underrun       = underrun_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_bridge_sched.sv
// Directed bench for bridge_sched: loader write, prefetch fill, sample delivery, wrap, underrun, error, reset.
module tb_bridge_sched;
    import bridge_sched_pkg::*;

    localparam logic [ADDR_W-1:0] TB_END = 26'd11;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              ld_we = 1'b0;
    logic [24:0]       ld_addr = '0;
    logic [15:0]       ld_data = '0;
    logic              ld_done = 1'b0;
    logic              ld_error = 1'b0;
    logic              ld_ack;
    logic              pb_enable = 1'b0;
    logic              smp_req = 1'b0;
    logic [15:0]       smp_data;
    logic              smp_valid;
    logic              underrun;
    logic [1:0]        state_o;

    int n_cmp = 0;
    int n_err = 0;
    int br_lat = 3;
    int req_age = 0;
    int wr_cnt = 0;
    int bad_addr = 0;
    logic [ADDR_W-1:0] rd_log [$];

    bridge_sched_if bus ();

    bridge_sched #(
        .FIFO_DEPTH (8),
        .END_ADDR   (TB_END)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_done   (ld_done),
        .ld_error  (ld_error),
        .ld_ack    (ld_ack),
        .pb_enable (pb_enable),
        .smp_req   (smp_req),
        .smp_data  (smp_data),
        .smp_valid (smp_valid),
        .underrun  (underrun),
        .state_o   (state_o),
        .br        (bus.master)
    );

    always #5 Clk = ~Clk;

    // Bridge responder: acknowledges in the br_lat-th cycle of a request, read data = address.
    always @(negedge Clk) begin
        if (Reset || !(bus.read || bus.write)) begin
            bus.acknowledge = 1'b0;
            req_age = 0;
        end else if (bus.acknowledge) begin
            bus.acknowledge = 1'b0;
        end else begin
            req_age++;
            if (req_age >= br_lat) begin
                bus.acknowledge = 1'b1;
                bus.read_data   = bus.address[15:0];
                if (bus.read) begin
                    rd_log.push_back(bus.address);
                    if (bus.address > TB_END) bad_addr++;
                end else begin
                    wr_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_expect(input string tag, input logic [15:0] exp);
        smp_req = 1'b1;
        tick();
        smp_req = 1'b0;
        chk({tag, "_valid"}, 32'(smp_valid), 32'd1);
        chk({tag, "_data"}, 32'(smp_data), 32'(exp));
        tick();
        chk({tag, "_valid_drop"}, 32'(smp_valid), 32'd0);
    endtask

    initial begin
        // Reset state
        ticks(2);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_write", 32'(bus.write), 32'd0);
        chk("rst_read", 32'(bus.read), 32'd0);
        chk("rst_be", 32'(bus.byte_enable), 32'd0);
        chk("rst_ld_ack", 32'(ld_ack), 32'd0);
        chk("rst_smp_valid", 32'(smp_valid), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        Reset = 1'b0;

        // 1: loader write held for three cycles, single ld_ack pulse
        br_lat  = 3;
        ld_we   = 1'b1;
        ld_addr = 25'h000010;
        ld_data = 16'hBEEF;
        tick();
        chk("w_c0_write", 32'(bus.write), 32'd1);
        chk("w_c0_addr", 32'(bus.address), 32'h10);
        chk("w_c0_data", 32'(bus.write_data), 32'hBEEF);
        chk("w_c0_be", 32'(bus.byte_enable), 32'h3);
        tick();
        chk("w_c1_write", 32'(bus.write), 32'd1);
        chk("w_c1_addr", 32'(bus.address), 32'h10);
        tick();
        chk("w_c2_write", 32'(bus.write), 32'd1);
        chk("w_c2_ld_ack", 32'(ld_ack), 32'd0);
        tick();
        chk("w_c3_write", 32'(bus.write), 32'd0);
        chk("w_c3_ld_ack", 32'(ld_ack), 32'd1);
        ld_we = 1'b0;
        tick();
        chk("w_c4_ld_ack", 32'(ld_ack), 32'd0);
        chk("w_c4_write", 32'(bus.write), 32'd0);

        // 2: enter PLAY, prefetch fills the FIFO with addresses 0..7 then stops
        br_lat  = 2;
        ld_done = 1'b1;
        tick();
        chk("play_state", 32'(state_o), 32'd1);
        pb_enable = 1'b1;
        ticks(40);
        chk("fill_reads", 32'(rd_log.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk("fill_addr", 32'(rd_log[i]), 32'(i));
        ticks(10);
        chk("fill_stop", 32'(rd_log.size()), 32'd8);
        chk("fill_no_read", 32'(bus.read), 32'd0);
        chk("wr_count", 32'(wr_cnt), 32'd1);

        // 3: four samples 0..3 with latency 1, reads resume at 8
        for (int i = 0; i < 4; i++) pop_expect("pop_a", 16'(i));
        ticks(40);
        chk("resume_reads", 32'(rd_log.size()), 32'd12);
        chk("resume_addr8", 32'(rd_log[8]), 32'd8);
        chk("resume_addr11", 32'(rd_log[11]), 32'd11);

        // 4: wrap from END_ADDR to 0
        for (int i = 4; i < 7; i++) pop_expect("pop_b", 16'(i));
        ticks(30);
        chk("wrap_reads", 32'(rd_log.size()), 32'd15);
        chk("wrap_addr0", 32'(rd_log[12]), 32'd0);
        chk("wrap_addr2", 32'(rd_log[14]), 32'd2);
        chk("wrap_no_past_end", 32'(bad_addr), 32'd0);

        // 5: disable prefetch, drain, then underrun
        pb_enable = 1'b0;
        ticks(2);
        for (int i = 7; i < 12; i++) pop_expect("drain", 16'(i));
        for (int i = 0; i < 3; i++) pop_expect("drain_wr", 16'(i));
        chk("pre_underrun", 32'(underrun), 32'd0);
        pop_expect("underrun_smp", 16'h0000);
        chk("underrun_set", 32'(underrun), 32'd1);
        ticks(5);
        chk("underrun_sticky", 32'(underrun), 32'd1);
        chk("no_read_disabled", 32'(rd_log.size()), 32'd15);

        // 6a: ld_error beats ld_done, ERROR is inert
        Reset = 1'b1;
        tick();
        chk("rst2_state", 32'(state_o), 32'd0);
        chk("rst2_underrun", 32'(underrun), 32'd0);
        Reset    = 1'b0;
        ld_done  = 1'b1;
        ld_error = 1'b1;
        ld_we    = 1'b1;
        tick();
        chk("err_state", 32'(state_o), 32'd2);
        ld_done   = 1'b0;
        ld_error  = 1'b0;
        pb_enable = 1'b1;
        smp_req   = 1'b1;
        ticks(5);
        smp_req = 1'b0;
        chk("err_state_hold", 32'(state_o), 32'd2);
        chk("err_no_write", 32'(bus.write), 32'd0);
        chk("err_no_read", 32'(bus.read), 32'd0);
        chk("err_no_valid", 32'(smp_valid), 32'd0);
        chk("err_wr_count", 32'(wr_cnt), 32'd1);
        ld_we = 1'b0;

        // 6b: reset in the middle of a read drops everything at once
        Reset = 1'b1;
        tick();
        Reset   = 1'b0;
        ld_done = 1'b1;
        for (int i = 0; i < 10 && !bus.read; i++) tick();
        chk("mid_read_issued", 32'(bus.read), 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_rst_read", 32'(bus.read), 32'd0);
        chk("async_rst_be", 32'(bus.byte_enable), 32'd0);
        chk("async_rst_state", 32'(state_o), 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
